// File: rtl/dsp_sop_pkg.sv
// Shared constants, tag type and latency helper for the SOP chain array.
// Optional feature macro: DSP_SOP_ACCUM_EN (per-channel multi-vector accumulator).
package dsp_sop_pkg;

    localparam int DEF_N_CH    = 8;
    localparam int DEF_N_TERMS = 4;
    localparam int DEF_A_W     = 18;
    localparam int DEF_B_W     = 19;
    localparam int DEF_ACC_W   = 37;

`ifdef DSP_SOP_ACCUM_EN
    localparam bit ACCUM_EN = 1'b1;
`else
    localparam bit ACCUM_EN = 1'b0;
`endif

    typedef struct packed {
        logic valid;
        logic last;
    } sop_tag_t;

    // Input register + one register per cascade stage + output register,
    // plus one more when the accumulator follows the output register.
    function automatic int sop_latency(input int n_terms, input bit accum);
        return n_terms + 2 + (accum ? 1 : 0);
    endfunction

endpackage

// File: rtl/dsp_sop_chain.sv
// One signed sum-of-products channel: input register, operand skew,
// systolic multiply-add cascade, output register and (with
// DSP_SOP_ACCUM_EN) a group accumulator behind the output register.
module dsp_sop_chain
    import dsp_sop_pkg::*;
#(
    parameter int N_TERMS = DEF_N_TERMS,
    parameter int A_W     = DEF_A_W,
    parameter int B_W     = DEF_B_W,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [N_TERMS*A_W-1:0] a,
    input  logic [N_TERMS*B_W-1:0] b,
`ifdef DSP_SOP_ACCUM_EN
    input  sop_tag_t               res_tag,
`else
    input  logic                   load,
`endif
    output logic [ACC_W-1:0]       sum
);

    localparam int PW = A_W + B_W;

    logic [N_TERMS*A_W-1:0] a_q;
    logic [N_TERMS*B_W-1:0] b_q;
    logic signed [A_W-1:0]  a_t  [N_TERMS];
    logic signed [B_W-1:0]  b_t  [N_TERMS];
    logic signed [PW-1:0]   p_t  [N_TERMS];
    logic [ACC_W-1:0]       prod [N_TERMS];
    logic [ACC_W-1:0]       s    [N_TERMS];

    // Input register for this channel's operand slice
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if (en) begin
            a_q <= a;
            b_q <= b;
        end
    end

    generate
        for (genvar t = 0; t < N_TERMS; t++) begin : g_term
            if (t == 0) begin : g_direct
                assign a_t[t] = a_q[t*A_W +: A_W];
                assign b_t[t] = b_q[t*B_W +: B_W];
            end else begin : g_skew
                logic [A_W-1:0] da [t];
                logic [B_W-1:0] db [t];

                // Delay term t operands by t cycles so they meet cascade stage t
                always_ff @(posedge clk) begin
                    if (reset) begin
                        for (int unsigned i = 0; i < t; i++) begin
                            da[i] <= '0;
                            db[i] <= '0;
                        end
                    end else if (en) begin
                        da[0] <= a_q[t*A_W +: A_W];
                        db[0] <= b_q[t*B_W +: B_W];
                        for (int unsigned i = 1; i < t; i++) begin
                            da[i] <= da[i-1];
                            db[i] <= db[i-1];
                        end
                    end
                end

                assign a_t[t] = da[t-1];
                assign b_t[t] = db[t-1];
            end

            // Full-precision signed product, then sign-extend/truncate to ACC_W
            assign p_t[t]  = PW'(a_t[t]) * PW'(b_t[t]);
            assign prod[t] = ACC_W'(p_t[t]);
        end
    endgenerate

    // Systolic cascade: each stage adds its product to the previous partial sum
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_TERMS; i++) s[i] <= '0;
        end else if (en) begin
            s[0] <= prod[0];
            for (int unsigned i = 1; i < N_TERMS; i++) s[i] <= s[i-1] + prod[i];
        end
    end

`ifdef DSP_SOP_ACCUM_EN
    logic [ACC_W-1:0] res_q;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic             first;

    // Output register of the cascade, feeding the accumulator
    always_ff @(posedge clk) begin
        if (reset)   res_q <= '0;
        else if (en) res_q <= s[N_TERMS-1];
    end

    // Next group total: restart from zero after a group closed
    always_comb begin
        acc_next = (first ? '0 : acc) + res_q;
    end

    // Accumulate valid results; publish the total only on the last of a group
    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            first <= 1'b1;
            sum   <= '0;
        end else if (en && res_tag.valid) begin
            acc   <= acc_next;
            first <= res_tag.last;
            if (res_tag.last) sum <= acc_next;
        end
    end
`else
    // Output register: only valid results update it, otherwise it holds
    always_ff @(posedge clk) begin
        if (reset)           sum <= '0;
        else if (en && load) sum <= s[N_TERMS-1];
    end
`endif

endmodule

// File: rtl/dsp_sop_chain_array.sv
// N_CH independent SOP channels sharing one valid/last tag pipeline.
// Optional feature macro: DSP_SOP_ACCUM_EN (group accumulation on in_last).
module dsp_sop_chain_array
    import dsp_sop_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int N_TERMS = DEF_N_TERMS,
    parameter int A_W     = DEF_A_W,
    parameter int B_W     = DEF_B_W,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic [N_CH*N_TERMS*A_W-1:0] in_a,
    input  logic [N_CH*N_TERMS*B_W-1:0] in_b,
    input  logic                        in_last,
    output logic                        out_valid,
    output logic [N_CH*ACC_W-1:0]       out_sum
);

    // Tag stage 0 sits beside the input register, stage i+1 beside cascade stage i
    localparam int TAG_DEPTH = sop_latency(N_TERMS, 1'b0) - 1;

    sop_tag_t tag_q [TAG_DEPTH];

    // Shared tag pipeline travelling alongside every channel's data
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
        end else if (en) begin
            tag_q[0].valid <= in_valid;
            tag_q[0].last  <= in_last;
            for (int unsigned i = 1; i < TAG_DEPTH; i++) tag_q[i] <= tag_q[i-1];
        end
    end

`ifdef DSP_SOP_ACCUM_EN
    sop_tag_t res_tag;

    // Tag for the cascade output register ahead of the accumulator
    always_ff @(posedge clk) begin
        if (reset)   res_tag <= '0;
        else if (en) res_tag <= tag_q[TAG_DEPTH-1];
    end

    // A result is presented only when a group closes
    always_ff @(posedge clk) begin
        if (reset)   out_valid <= 1'b0;
        else if (en) out_valid <= res_tag.valid & res_tag.last;
    end
`else
    logic unused_last;
    assign unused_last = tag_q[TAG_DEPTH-1].last;

    // Output valid aligned with the channel output registers
    always_ff @(posedge clk) begin
        if (reset)   out_valid <= 1'b0;
        else if (en) out_valid <= tag_q[TAG_DEPTH-1].valid;
    end
`endif

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            dsp_sop_chain #(
                .N_TERMS (N_TERMS),
                .A_W     (A_W),
                .B_W     (B_W),
                .ACC_W   (ACC_W)
            ) u_chain (
                .clk     (clk),
                .reset   (reset),
                .en      (en),
                .a       (in_a[c*N_TERMS*A_W +: N_TERMS*A_W]),
                .b       (in_b[c*N_TERMS*B_W +: N_TERMS*B_W]),
`ifdef DSP_SOP_ACCUM_EN
                .res_tag (res_tag),
`else
                .load    (tag_q[TAG_DEPTH-1].valid),
`endif
                .sum     (out_sum[c*ACC_W +: ACC_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_dsp_sop_chain_array.sv
// Directed/random bench for dsp_sop_chain_array with an expected-result queue.
// Handles both builds (DSP_SOP_ACCUM_EN defined or not).
module tb_dsp_sop_chain_array;

    localparam int N_CH    = 8;
    localparam int N_TERMS = 4;
    localparam int A_W     = 18;
    localparam int B_W     = 19;
    localparam int ACC_W   = 37;
    localparam int AV      = N_CH*N_TERMS*A_W;
    localparam int BV      = N_CH*N_TERMS*B_W;
    localparam int OW      = N_CH*ACC_W;
`ifdef DSP_SOP_ACCUM_EN
    localparam int LAT = N_TERMS + 3;
`else
    localparam int LAT = N_TERMS + 2;
`endif

    logic          clk;
    logic          reset;
    logic          en;
    logic          in_valid;
    logic [AV-1:0] in_a;
    logic [BV-1:0] in_b;
    logic          in_last;
    logic          out_valid;
    logic [OW-1:0] out_sum;

    dsp_sop_chain_array #(
        .N_CH    (N_CH),
        .N_TERMS (N_TERMS),
        .A_W     (A_W),
        .B_W     (B_W),
        .ACC_W   (ACC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_sum   (out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] sum;
        int            due;
    } exp_t;

    exp_t             q[$];
    int               ncmp = 0;
    int               nbad = 0;
    int               ecyc = 0;
    logic             pv = 1'b0;
    logic [OW-1:0]    ps = '0;
    logic [ACC_W-1:0] macc [N_CH];
    bit               mfirst = 1'b1;

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nbad++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [AV-1:0] mk_a(input int t0, input int t1, input int t2, input int t3);
        logic [AV-1:0] r;
        int v [4];
        v[0] = t0; v[1] = t1; v[2] = t2; v[3] = t3;
        for (int c = 0; c < N_CH; c++)
            for (int t = 0; t < N_TERMS; t++) r[(c*N_TERMS+t)*A_W +: A_W] = A_W'(v[t]);
        return r;
    endfunction

    function automatic logic [BV-1:0] mk_b(input int t0, input int t1, input int t2, input int t3);
        logic [BV-1:0] r;
        int v [4];
        v[0] = t0; v[1] = t1; v[2] = t2; v[3] = t3;
        for (int c = 0; c < N_CH; c++)
            for (int t = 0; t < N_TERMS; t++) r[(c*N_TERMS+t)*B_W +: B_W] = B_W'(v[t]);
        return r;
    endfunction

    function automatic logic [AV-1:0] rnd_a();
        logic [AV-1:0] r;
        for (int i = 0; i < N_CH*N_TERMS; i++) r[i*A_W +: A_W] = A_W'($urandom);
        return r;
    endfunction

    function automatic logic [BV-1:0] rnd_b();
        logic [BV-1:0] r;
        for (int i = 0; i < N_CH*N_TERMS; i++) r[i*B_W +: B_W] = B_W'($urandom);
        return r;
    endfunction

    function automatic logic [ACC_W-1:0] chan_sum(input logic [AV-1:0] a, input logic [BV-1:0] b, input int c);
        longint acc = 0;
        for (int t = 0; t < N_TERMS; t++)
            acc += longint'($signed(a[(c*N_TERMS+t)*A_W +: A_W])) *
                   longint'($signed(b[(c*N_TERMS+t)*B_W +: B_W]));
        return ACC_W'(acc);
    endfunction

    task automatic model_reset();
        q.delete();
        mfirst = 1'b1;
        for (int c = 0; c < N_CH; c++) macc[c] = '0;
    endtask

    task automatic accept(input logic [AV-1:0] a, input logic [BV-1:0] b, input bit l);
        exp_t e;
        e.due = ecyc + LAT - 1;
        for (int c = 0; c < N_CH; c++) begin
`ifdef DSP_SOP_ACCUM_EN
            if (mfirst) macc[c] = chan_sum(a, b, c);
            else        macc[c] = macc[c] + chan_sum(a, b, c);
            e.sum[c*ACC_W +: ACC_W] = macc[c];
`else
            e.sum[c*ACC_W +: ACC_W] = chan_sum(a, b, c);
`endif
        end
`ifdef DSP_SOP_ACCUM_EN
        mfirst = l;
        if (l) q.push_back(e);
`else
        q.push_back(e);
`endif
    endtask

    // One clock: drive inputs, update the model at the edge, check #1 later
    task automatic step(input bit e, input bit v, input bit l,
                        input logic [AV-1:0] a, input logic [BV-1:0] b, input bit r);
        bit   expect_now;
        exp_t ex;
        reset = r; en = e; in_valid = v; in_last = l; in_a = a; in_b = b;
        @(posedge clk);
        if (r) model_reset();
        else if (e) begin
            ecyc++;
            if (v) accept(a, b, l);
        end
        #1;
        if (r) begin
            chk("rst_valid", OW'(out_valid), '0);
            chk("rst_sum", out_sum, '0);
        end else begin
            if (e) begin
                expect_now = (q.size() > 0) && (q[0].due == ecyc);
                chk("valid", OW'(out_valid), OW'(expect_now));
                if (expect_now) begin
                    ex = q.pop_front();
                    if (out_valid) chk("sum", out_sum, ex.sum);
                end
            end else begin
                chk("hold_valid", OW'(out_valid), OW'(pv));
            end
            if (!(e && out_valid)) chk("hold_sum", out_sum, ps);
        end
        pv = out_valid;
        ps = out_sum;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        int nacc;
        bit e, v;
        model_reset();

        // Reset state
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);

        // Basic vector: 1*5+2*6+3*7+4*8 = 70 on every channel
        step(1'b1, 1'b1, 1'b1, mk_a(1, 2, 3, 4), mk_b(5, 6, 7, 8), 1'b0);
        idle(LAT + 2);

        // Signed extremes, including wrap modulo 2^37
        step(1'b1, 1'b1, 1'b1, mk_a(-131072, -131072, -131072, -131072),
             mk_b(-262144, -262144, -262144, -262144), 1'b0);
        step(1'b1, 1'b1, 1'b1, mk_a(-131072, -131072, -131072, -131072),
             mk_b(262143, 262143, 262143, 262143), 1'b0);
        step(1'b1, 1'b1, 1'b1, mk_a(131071, -131072, 131071, 1),
             mk_b(262143, 262143, -262144, -1), 1'b0);
        idle(LAT + 2);

        // 20 accepted random vectors with en toggling and idle beats mixed in
        nacc = 0;
        for (int i = 0; i < 400 && nacc < 20; i++) begin
            e = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 4) != 0);
            step(e, v, 1'b1, rnd_a(), rnd_b(), 1'b0);
            if (e && v) nacc++;
        end
        chk("rand_accepted", OW'(nacc), OW'(20));
        for (int i = 0; i < 200 && q.size() > 0; i++)
            step($urandom_range(0, 2) != 0, 1'b0, 1'b0, rnd_a(), rnd_b(), 1'b0);
        chk("rand_drained", OW'(q.size()), '0);
        idle(2);

        // Reset with three vectors in flight discards them
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, rnd_a(), rnd_b(), 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        idle(LAT + 4);
        chk("post_rst_sum", out_sum, '0);
        step(1'b1, 1'b1, 1'b1, rnd_a(), rnd_b(), 1'b0);
        idle(LAT + 2);

`ifdef DSP_SOP_ACCUM_EN
        // Group 70+10-5 = 75, then single-vector group 7
        step(1'b1, 1'b1, 1'b0, mk_a(1, 2, 3, 4), mk_b(5, 6, 7, 8), 1'b0);
        step(1'b1, 1'b1, 1'b0, mk_a(10, 0, 0, 0), mk_b(1, 0, 0, 0), 1'b0);
        step(1'b1, 1'b1, 1'b1, mk_a(-5, 0, 0, 0), mk_b(1, 0, 0, 0), 1'b0);
        step(1'b1, 1'b1, 1'b1, mk_a(7, 0, 0, 0), mk_b(1, 0, 0, 0), 1'b0);
        idle(LAT + 2);

        // Invalid beat carrying in_last inside a group must be ignored
        step(1'b1, 1'b1, 1'b0, mk_a(3, 0, 0, 0), mk_b(1, 0, 0, 0), 1'b0);
        step(1'b1, 1'b0, 1'b1, mk_a(100, 0, 0, 0), mk_b(1, 0, 0, 0), 1'b0);
        step(1'b0, 1'b1, 1'b1, mk_a(50, 0, 0, 0), mk_b(1, 0, 0, 0), 1'b0);
        step(1'b1, 1'b1, 1'b1, mk_a(4, 0, 0, 0), mk_b(1, 0, 0, 0), 1'b0);
        idle(LAT + 2);
`endif

        chk("final_drained", OW'(q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
